// File: rtl/pwm_pkg.sv
// Shared PWM types and constants: sequencer state encoding, field widths and
// the default duty/period values also used by the adjust logic and generator.
package pwm_pkg;

    localparam int DUTY_W    = 8;
    localparam int COUNT_P_W = 24;

    localparam int DEF_DUTY         = 50;
    localparam int DEF_COUNT_P      = 250_000;
    localparam int DEF_DUTY_STEP    = 10;
    localparam int DEF_DUTY_MAX     = 100;
    localparam int DEF_DUTY_MIN     = 0;
    localparam int DEF_HOLD_PERIODS = 4;
    localparam int DEF_PERIOD_STEP  = 50_000;
    localparam int DEF_PERIOD_MIN   = 50_000;
    localparam int DEF_PERIOD_MAX   = 500_000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [DUTY_W-1:0]    duty;
        logic [COUNT_P_W-1:0] count_p;
    } pwm_cfg_t;

    function automatic int clamp_i(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/pwm_seq_hold_counter.sv
// Counts Period_End ticks while a hold state is active; o_done fires
// combinationally on the HOLD_PERIODS-th tick after the last clear.
module pwm_seq_hold_counter #(
    parameter int HOLD_PERIODS = 4
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_done
);

    logic [7:0] r_cnt;

    assign o_done = i_tick && (r_cnt == 8'(HOLD_PERIODS - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= o_done ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_profile_sequencer.sv
// Breathing-profile sequencer: ramps Duty between limits with holds and commits
// every change on a PWM period boundary. PWM_SEQ_PERIOD_SWEEP_EN adds a Count_P sweep.
module pwm_profile_sequencer
    import pwm_pkg::*;
#(
    parameter int DUTY_STEP    = DEF_DUTY_STEP,
    parameter int DUTY_MAX     = DEF_DUTY_MAX,
    parameter int DUTY_MIN     = DEF_DUTY_MIN,
    parameter int HOLD_PERIODS = DEF_HOLD_PERIODS,
    parameter int RST_DUTY     = DEF_DUTY,
    parameter int RST_COUNT_P  = DEF_COUNT_P,
`ifdef PWM_SEQ_PERIOD_SWEEP_EN
    parameter int PERIOD_STEP  = DEF_PERIOD_STEP,
`endif
    parameter int PERIOD_MIN   = DEF_PERIOD_MIN,
    parameter int PERIOD_MAX   = DEF_PERIOD_MAX
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 Period_End,
    input  logic                 Manual_Valid,
    input  logic [DUTY_W-1:0]    Manual_Duty,
    input  logic [COUNT_P_W-1:0] Manual_Count_P,
    output logic [DUTY_W-1:0]    Duty,
    output logic [COUNT_P_W-1:0] Count_P,
    output logic                 Load,
    output logic                 Busy,
    output logic [2:0]           State
);

    seq_state_e r_state;
    pwm_cfg_t   r_cfg;
    pwm_cfg_t   r_pend;
    logic       r_pend_vld;
    logic       r_load;
    logic       r_busy;

    int                   w_duty_up;
    int                   w_duty_dn;
    logic [DUTY_W-1:0]    w_duty_up_sat;
    logic [DUTY_W-1:0]    w_duty_dn_sat;
    logic [COUNT_P_W-1:0] w_cp_up;
    logic [COUNT_P_W-1:0] w_cp_dn;
    logic [DUTY_W-1:0]    w_man_duty;
    logic [COUNT_P_W-1:0] w_man_cp;
    logic                 w_in_hold;
    logic                 w_hold_done;

    // Ramp arithmetic in int so neither the add nor the subtract can wrap.
    assign w_duty_up     = int'(r_cfg.duty) + DUTY_STEP;
    assign w_duty_dn     = int'(r_cfg.duty) - DUTY_STEP;
    assign w_duty_up_sat = DUTY_W'((w_duty_up > DUTY_MAX) ? DUTY_MAX : w_duty_up);
    assign w_duty_dn_sat = DUTY_W'((w_duty_dn < DUTY_MIN) ? DUTY_MIN : w_duty_dn);

`ifdef PWM_SEQ_PERIOD_SWEEP_EN
    // Brighter means shorter period: ramp-up shrinks Count_P, ramp-down grows it.
    assign w_cp_up = COUNT_P_W'(clamp_i(int'(r_cfg.count_p) - PERIOD_STEP, PERIOD_MIN, PERIOD_MAX));
    assign w_cp_dn = COUNT_P_W'(clamp_i(int'(r_cfg.count_p) + PERIOD_STEP, PERIOD_MIN, PERIOD_MAX));
`else
    assign w_cp_up = r_cfg.count_p;
    assign w_cp_dn = r_cfg.count_p;
`endif

    assign w_man_duty = DUTY_W'(clamp_i(int'(r_pend.duty), DUTY_MIN, DUTY_MAX));
    assign w_man_cp   = COUNT_P_W'(clamp_i(int'(r_pend.count_p), PERIOD_MIN, PERIOD_MAX));

    // Counter is held clear outside the hold states, so it starts at zero on entry.
    assign w_in_hold = (r_state == HOLD_HIGH) || (r_state == HOLD_LOW);

    pwm_seq_hold_counter #(
        .HOLD_PERIODS(HOLD_PERIODS)
    ) u_hold (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .i_clear(!w_in_hold),
        .i_tick (Period_End && w_in_hold),
        .o_done (w_hold_done)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= IDLE;
            r_cfg      <= '{duty: DUTY_W'(RST_DUTY), count_p: COUNT_P_W'(RST_COUNT_P)};
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_load     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (Stop && r_state != IDLE) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (Period_End && r_pend_vld) begin
                            r_cfg      <= '{duty: w_man_duty, count_p: w_man_cp};
                            r_load     <= 1'b1;
                            r_pend_vld <= 1'b0;
                        end
                        // A same-cycle Manual_Valid re-arms the pending slot after the commit.
                        if (Manual_Valid) begin
                            r_pend     <= '{duty: Manual_Duty, count_p: Manual_Count_P};
                            r_pend_vld <= 1'b1;
                        end
                        if (Start && !Stop) begin
                            r_state <= RAMP_UP;
                            r_busy  <= 1'b1;
                        end
                    end
                    RAMP_UP: begin
                        if (Period_End) begin
                            if (int'(r_cfg.duty) >= DUTY_MAX) begin
                                r_state <= HOLD_HIGH;
                            end else begin
                                r_cfg  <= '{duty: w_duty_up_sat, count_p: w_cp_up};
                                r_load <= 1'b1;
                                if (w_duty_up >= DUTY_MAX) r_state <= HOLD_HIGH;
                            end
                        end
                    end
                    HOLD_HIGH: begin
                        if (w_hold_done) r_state <= RAMP_DOWN;
                    end
                    RAMP_DOWN: begin
                        if (Period_End) begin
                            if (int'(r_cfg.duty) <= DUTY_MIN) begin
                                r_state <= HOLD_LOW;
                            end else begin
                                r_cfg  <= '{duty: w_duty_dn_sat, count_p: w_cp_dn};
                                r_load <= 1'b1;
                                if (w_duty_dn <= DUTY_MIN) r_state <= HOLD_LOW;
                            end
                        end
                    end
                    HOLD_LOW: begin
                        if (w_hold_done) r_state <= RAMP_UP;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Duty    = r_cfg.duty;
    assign Count_P = r_cfg.count_p;
    assign Load    = r_load;
    assign Busy    = r_busy;
    assign State   = r_state;

endmodule

// File: tb/tb_pwm_profile_sequencer.sv
// Directed bench for pwm_profile_sequencer; Count_P expectations follow
// PWM_SEQ_PERIOD_SWEEP_EN when the bench is built with it.
module tb_pwm_profile_sequencer;

`ifdef PWM_SEQ_PERIOD_SWEEP_EN
    localparam bit SW = 1'b1;
`else
    localparam bit SW = 1'b0;
`endif
    localparam int CP0 = 250_000;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Start = 1'b0, Stop = 1'b0, Period_End = 1'b0, Manual_Valid = 1'b0;
    logic [7:0]  Manual_Duty = '0;
    logic [23:0] Manual_Count_P = '0;
    logic [7:0]  Duty;
    logic [23:0] Count_P;
    logic        Load, Busy;
    logic [2:0]  State;

    int nvec = 0;
    int nerr = 0;

    int up_d [5] = '{60, 70, 80, 90, 100};
    int up_c [5] = '{200_000, 150_000, 100_000, 50_000, 50_000};
    int dn_d [10] = '{90, 80, 70, 60, 50, 40, 30, 20, 10, 0};
    int dn_c [10] = '{100_000, 150_000, 200_000, 250_000, 300_000,
                      350_000, 400_000, 450_000, 500_000, 500_000};
    int up2_d [7] = '{10, 20, 30, 40, 50, 60, 70};
    int up2_c [7] = '{450_000, 400_000, 350_000, 300_000, 250_000, 200_000, 150_000};

    always #5 CLK = ~CLK;

    pwm_profile_sequencer dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .Start         (Start),
        .Stop          (Stop),
        .Period_End    (Period_End),
        .Manual_Valid  (Manual_Valid),
        .Manual_Duty   (Manual_Duty),
        .Manual_Count_P(Manual_Count_P),
        .Duty          (Duty),
        .Count_P       (Count_P),
        .Load          (Load),
        .Busy          (Busy),
        .State         (State)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One Period_End pulse, check the commit cycle, then check the cycle after.
    task automatic period(input string tag, input int d, input int cp, input bit ld);
        Period_End = 1'b1;
        tick();
        Period_End = 1'b0;
        chk({tag, ".load"}, 32'(Load), 32'(ld));
        chk({tag, ".duty"}, 32'(Duty), d);
        chk({tag, ".cp"}, 32'(Count_P), cp);
        tick();
        chk({tag, ".load_off"}, 32'(Load), 0);
        chk({tag, ".duty_hold"}, 32'(Duty), d);
    endtask

    task automatic mv(input int d, input int cp);
        Manual_Valid   = 1'b1;
        Manual_Duty    = 8'(d);
        Manual_Count_P = 24'(cp);
        tick();
        Manual_Valid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst.duty", 32'(Duty), 50);
        chk("rst.cp", 32'(Count_P), CP0);
        chk("rst.load", 32'(Load), 0);
        chk("rst.busy", 32'(Busy), 0);
        chk("rst.state", 32'(State), 0);
        RSTn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) period($sformatf("idle%0d", i), 50, CP0, 1'b0);
        chk("idle.busy", 32'(Busy), 0);

        // Manual load clamps high and waits for the period boundary.
        mv(130, 600_000);
        repeat (3) tick();
        chk("man_wait.duty", 32'(Duty), 50);
        chk("man_wait.cp", 32'(Count_P), CP0);
        chk("man_wait.load", 32'(Load), 0);
        period("man_hi", 100, 500_000, 1'b1);

        // Later Manual_Valid overwrites; Count_P clamps low.
        mv(200, 10);
        mv(5, 10_000);
        period("man_lo", 5, 50_000, 1'b1);
        period("man_nopend", 5, 50_000, 1'b0);
        mv(50, CP0);
        period("man_restore", 50, CP0, 1'b1);

        pulse_start();
        chk("start.state", 32'(State), 1);
        chk("start.busy", 32'(Busy), 1);
        chk("start.duty", 32'(Duty), 50);
        chk("start.load", 32'(Load), 0);

        for (int i = 0; i < 5; i++)
            period($sformatf("up%0d", i), up_d[i], SW ? up_c[i] : CP0, 1'b1);
        chk("hh.state", 32'(State), 2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hh%0d.state", i), 32'(State), 2);
            period($sformatf("hh%0d", i), 100, SW ? up_c[4] : CP0, 1'b0);
        end
        chk("rd.state", 32'(State), 3);

        for (int i = 0; i < 10; i++)
            period($sformatf("dn%0d", i), dn_d[i], SW ? dn_c[i] : CP0, 1'b1);
        chk("hl.state", 32'(State), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hl%0d.state", i), 32'(State), 4);
            period($sformatf("hl%0d", i), 0, SW ? dn_c[9] : CP0, 1'b0);
        end
        chk("ru2.state", 32'(State), 1);

        for (int i = 0; i < 7; i++)
            period($sformatf("up2_%0d", i), up2_d[i], SW ? up2_c[i] : CP0, 1'b1);

        // Manual_Valid while busy is dropped; Stop beats a same-cycle Period_End.
        mv(30, 100_000);
        Stop = 1'b1;
        Period_End = 1'b1;
        tick();
        Stop = 1'b0;
        Period_End = 1'b0;
        chk("stop.load", 32'(Load), 0);
        chk("stop.duty", 32'(Duty), 70);
        chk("stop.cp", 32'(Count_P), SW ? 150_000 : CP0);
        chk("stop.state", 32'(State), 0);
        chk("stop.busy", 32'(Busy), 0);
        period("stop_nopend", 70, SW ? 150_000 : CP0, 1'b0);

        Start = 1'b1;
        Stop = 1'b1;
        tick();
        Start = 1'b0;
        Stop = 1'b0;
        chk("startstop.state", 32'(State), 0);
        chk("startstop.busy", 32'(Busy), 0);

        // Pending load queued in IDLE must be discarded by a mid-profile reset.
        mv(90, 300_000);
        pulse_start();
        period("pre_rst", 80, SW ? 100_000 : CP0, 1'b1);
        RSTn = 1'b0;
        #2;
        chk("midrst.duty", 32'(Duty), 50);
        chk("midrst.cp", 32'(Count_P), CP0);
        chk("midrst.state", 32'(State), 0);
        chk("midrst.busy", 32'(Busy), 0);
        tick();
        RSTn = 1'b1;
        period("post_rst", 50, CP0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
